// File: rtl/bank_pkg.sv
// Shared defaults and types for the bank return-path blocks.
package bank_pkg;

  // Default geometry of the bank return path.
  localparam int BANK_CH_NUM    = 4;
  localparam int BANK_ROB_DEPTH = 8;
  localparam int BANK_DATA_W    = 128;
  localparam int BANK_CH_W      = $clog2(BANK_CH_NUM);
  localparam int BANK_ROB_W     = $clog2(BANK_ROB_DEPTH);

  // Bookkeeping bits of one reorder-buffer entry.
  typedef struct packed {
    logic alloc;  // rob number handed out, not yet released
    logic fill;   // return data has arrived
  } rob_entry_t;

endpackage

// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last
// accepted one (wrapping). The pointer moves only on advance_i, so a
// stalled grant keeps its priority.
module bank_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] last_reg;
  logic [W-1:0] grant_idx;
  logic [W-1:0] scan_idx;
  logic         found;

  // Scan requesters starting just above the last accepted channel.
  always_comb begin
    grant_o   = '0;
    grant_idx = last_reg;
    scan_idx  = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      scan_idx = W'((int'(last_reg) + k) % N);
      if (!found && req_i[scan_idx]) begin
        grant_o[scan_idx] = 1'b1;
        grant_idx         = scan_idx;
        found             = 1'b1;
      end
    end
  end

  // Remember the accepted channel; reset to N-1 so channel 0 wins first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_reg <= W'(N - 1);
    end else if (advance_i && found) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/bank_xbar_rob.sv
// Per-channel reorder buffer on the bank->xbar return path. Hands out
// rob numbers, accepts out-of-order returns and releases them to the
// xbar in allocation order per channel, channels served round-robin.
module bank_xbar_rob
  import bank_pkg::*;
#(
  parameter int CH_NUM    = BANK_CH_NUM,
  parameter int ROB_DEPTH = BANK_ROB_DEPTH,
  parameter int DATA_W    = BANK_DATA_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [$clog2(CH_NUM)-1:0]    alloc_channel_id_i,
  output logic [$clog2(ROB_DEPTH)-1:0] alloc_rob_num_o,
  input  logic                         sc_xbar_valid_i,
  output logic                         sc_xbar_ready_o,
  input  logic [$clog2(CH_NUM)-1:0]    sc_xbar_channel_id_i,
  input  logic [$clog2(ROB_DEPTH)-1:0] sc_xbar_rob_num_i,
  input  logic [DATA_W-1:0]            sc_xbar_data_i,
  output logic                         xbar_rsp_valid_o,
  input  logic                         xbar_rsp_ready_i,
  output logic [$clog2(CH_NUM)-1:0]    xbar_rsp_channel_id_o,
  output logic [DATA_W-1:0]            xbar_rsp_data_o,
  output logic [CH_NUM-1:0]            rob_empty_o,
  output logic                         rob_err_o
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam logic [ROB_W:0] FULL_CNT = (ROB_W + 1)'(ROB_DEPTH);

  logic [ROB_W-1:0]  head_reg  [CH_NUM];
  logic [ROB_W-1:0]  tail_reg  [CH_NUM];
  logic [ROB_W:0]    count_reg [CH_NUM];
  rob_entry_t        ent_reg   [CH_NUM][ROB_DEPTH];
  logic [DATA_W-1:0] data_reg  [CH_NUM][ROB_DEPTH];

  logic            sc_ready_reg;
  logic            err_reg;
  logic            hold_reg;
  logic [CH_W-1:0] hold_ch_reg;

  logic [CH_NUM-1:0] eligible;
  logic [CH_NUM-1:0] arb_req;
  logic [CH_NUM-1:0] grant;
  logic [CH_NUM-1:0] alloc_hit;
  logic [CH_NUM-1:0] rel_hit;
  logic [CH_W-1:0]   rsp_ch;
  logic              alloc_fire;
  logic              fill_acc;
  logic              fill_ok;
  logic              rsp_fire;
  logic              stall;
  rob_entry_t        fill_ent;

  assign alloc_ready_o   = (count_reg[alloc_channel_id_i] != FULL_CNT);
  assign alloc_rob_num_o = tail_reg[alloc_channel_id_i];
  assign alloc_fire      = alloc_valid_i && alloc_ready_o;

  // A return is only legal into an allocated entry that is still empty.
  assign sc_xbar_ready_o = sc_ready_reg;
  assign fill_acc        = sc_xbar_valid_i && sc_ready_reg;
  assign fill_ent        = ent_reg[sc_xbar_channel_id_i][sc_xbar_rob_num_i];
  assign fill_ok         = fill_acc && fill_ent.alloc && !fill_ent.fill;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign eligible[gi]    = (count_reg[gi] != '0) && ent_reg[gi][head_reg[gi]].fill;
      assign alloc_hit[gi]   = alloc_fire && (alloc_channel_id_i == CH_W'(gi));
      assign rel_hit[gi]     = rsp_fire && grant[gi];
      assign rob_empty_o[gi] = (count_reg[gi] == '0);
    end
  endgenerate

  // While a response is stalled, present only the held channel to the
  // arbiter so grant, channel and data cannot move until accepted.
  always_comb begin
    arb_req = eligible;
    if (hold_reg) begin
      arb_req              = '0;
      arb_req[hold_ch_reg] = 1'b1;
    end
  end

  bank_rr_arbiter #(
    .N (CH_NUM)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (arb_req),
    .advance_i (rsp_fire),
    .grant_o   (grant)
  );

  // Encode the one-hot grant into the response channel number.
  always_comb begin
    rsp_ch = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (grant[c]) begin
        rsp_ch = rsp_ch | CH_W'(c);
      end
    end
  end

  assign xbar_rsp_valid_o      = |grant;
  assign xbar_rsp_channel_id_o = rsp_ch;
  assign xbar_rsp_data_o       = data_reg[rsp_ch][head_reg[rsp_ch]];
  assign rsp_fire              = xbar_rsp_valid_o && xbar_rsp_ready_i;
  assign stall                 = xbar_rsp_valid_o && !xbar_rsp_ready_i;
  assign rob_err_o             = err_reg;

  // Pointer, count, entry-bit and handshake-state updates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        head_reg[c]  <= '0;
        tail_reg[c]  <= '0;
        count_reg[c] <= '0;
        for (int e = 0; e < ROB_DEPTH; e++) begin
          ent_reg[c][e] <= '0;
        end
      end
      sc_ready_reg <= 1'b0;
      err_reg      <= 1'b0;
      hold_reg     <= 1'b0;
      hold_ch_reg  <= '0;
    end else begin
      sc_ready_reg <= 1'b1;
      err_reg      <= fill_acc && !fill_ok;
      hold_reg     <= stall;
      if (stall) begin
        hold_ch_reg <= rsp_ch;
      end
      // Allocation writes the tail entry and release clears the head
      // entry; these never coincide (full blocks alloc, empty blocks release).
      for (int c = 0; c < CH_NUM; c++) begin
        if (alloc_hit[c]) begin
          ent_reg[c][tail_reg[c]].alloc <= 1'b1;
          tail_reg[c]                   <= tail_reg[c] + 1'b1;
        end
        if (rel_hit[c]) begin
          ent_reg[c][head_reg[c]] <= '0;
          head_reg[c]             <= head_reg[c] + 1'b1;
        end
        count_reg[c] <= count_reg[c] + (ROB_W + 1)'(alloc_hit[c])
                                     - (ROB_W + 1)'(rel_hit[c]);
      end
      // A legal fill never targets the entry being released (already filled).
      if (fill_ok) begin
        ent_reg[sc_xbar_channel_id_i][sc_xbar_rob_num_i].fill <= 1'b1;
      end
    end
  end

  // Single write port into the return-data array.
  always_ff @(posedge clk_i) begin
    if (fill_ok) begin
      data_reg[sc_xbar_channel_id_i][sc_xbar_rob_num_i] <= sc_xbar_data_i;
    end
  end

endmodule

// File: tb/tb_bank_xbar_rob.sv
// Directed bench for bank_xbar_rob: a vector table for the in-order
// release and error pulses, plus hand sequences for wrap, round-robin,
// stall hold and mid-stream reset.
module tb_bank_xbar_rob;

  logic         clk;
  logic         rst_i;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [1:0]   alloc_ch;
  logic [2:0]   alloc_rob;
  logic         sc_valid;
  logic         sc_ready;
  logic [1:0]   sc_ch;
  logic [2:0]   sc_rob;
  logic [127:0] sc_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_ch;
  logic [127:0] rsp_data;
  logic [3:0]   rob_empty;
  logic         rob_err;

  int checks = 0;
  int errors = 0;

  bank_xbar_rob dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .alloc_valid_i        (alloc_valid),
    .alloc_ready_o        (alloc_ready),
    .alloc_channel_id_i   (alloc_ch),
    .alloc_rob_num_o      (alloc_rob),
    .sc_xbar_valid_i      (sc_valid),
    .sc_xbar_ready_o      (sc_ready),
    .sc_xbar_channel_id_i (sc_ch),
    .sc_xbar_rob_num_i    (sc_rob),
    .sc_xbar_data_i       (sc_data),
    .xbar_rsp_valid_o     (rsp_valid),
    .xbar_rsp_ready_i     (rsp_ready),
    .xbar_rsp_channel_id_o(rsp_ch),
    .xbar_rsp_data_o      (rsp_data),
    .rob_empty_o          (rob_empty),
    .rob_err_o            (rob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [1:0]  ach;
    logic        fv;
    logic [1:0]  fch;
    logic [2:0]  frob;
    logic [31:0] fdata;
    logic        rdy;
    logic        e_ar;
    logic [2:0]  e_rob;
    logic        e_v;
    logic [1:0]  e_ch;
    logic [31:0] e_data;
    logic        e_err;
    logic [3:0]  e_empty;
  } vec_t;

  vec_t vecs [18];
  int   b_fch  [5];
  int   b_frob [5];
  int   b_rch  [5];
  int   b_rrob [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alloc_valid = 1'b0;
    alloc_ch    = 2'd0;
    sc_valid    = 1'b0;
    sc_ch       = 2'd0;
    sc_rob      = 3'd0;
    sc_data     = '0;
    rsp_ready   = 1'b1;
  endtask

  task automatic alloc(input logic [1:0] ch, input logic [2:0] exp_rob, input logic exp_rdy);
    alloc_valid = 1'b1;
    alloc_ch    = ch;
    #1;
    check("alloc_ready", alloc_ready, exp_rdy);
    if (exp_rdy) check("alloc_rob", alloc_rob, exp_rob);
    $display("alloc ch=%0d rob=%0d ready=%0b", ch, alloc_rob, alloc_ready);
    next();
    alloc_valid = 1'b0;
  endtask

  task automatic fill(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] d);
    sc_valid = 1'b1;
    sc_ch    = ch;
    sc_rob   = rob;
    sc_data  = d;
  endtask

  task automatic expect_rsp(input string name, input logic [1:0] ch, input logic [127:0] d);
    check({name, "_valid"}, rsp_valid, 1'b1);
    check({name, "_ch"}, rsp_ch, ch);
    check({name, "_data"}, rsp_data, d);
    $display("rsp %s ch=%0d data=%0h ready=%0b", name, rsp_ch, rsp_data, rsp_ready);
  endtask

  initial begin
    // av ach fv fch frob fdata rdy | ar rob v ch data err empty
    vecs[0]  = '{1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,        0, 4'b1111};
    vecs[1]  = '{1, 1, 0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 32'h0,        0, 4'b1101};
    vecs[2]  = '{1, 1, 0, 0, 0, 32'h0,        1, 1, 2, 0, 0, 32'h0,        0, 4'b1101};
    vecs[3]  = '{0, 1, 1, 1, 2, 32'hAAAA0002, 1, 1, 3, 0, 0, 32'h0,        0, 4'b1101};
    vecs[4]  = '{0, 1, 1, 1, 0, 32'hBBBB0000, 1, 1, 3, 0, 0, 32'h0,        0, 4'b1101};
    vecs[5]  = '{0, 1, 1, 1, 1, 32'hCCCC0001, 1, 1, 3, 1, 1, 32'hBBBB0000, 0, 4'b1101};
    vecs[6]  = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 3, 1, 1, 32'hCCCC0001, 0, 4'b1101};
    vecs[7]  = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 3, 1, 1, 32'hAAAA0002, 0, 4'b1101};
    vecs[8]  = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 3, 0, 0, 32'h0,        0, 4'b1111};
    vecs[9]  = '{0, 1, 1, 1, 3, 32'h0000DEAD, 1, 1, 3, 0, 0, 32'h0,        0, 4'b1111};
    vecs[10] = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 3, 0, 0, 32'h0,        1, 4'b1111};
    vecs[11] = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 3, 0, 0, 32'h0,        0, 4'b1111};
    vecs[12] = '{1, 1, 0, 0, 0, 32'h0,        0, 1, 3, 0, 0, 32'h0,        0, 4'b1111};
    vecs[13] = '{0, 1, 1, 1, 3, 32'h00000033, 0, 1, 4, 0, 0, 32'h0,        0, 4'b1101};
    vecs[14] = '{0, 1, 1, 1, 3, 32'h00000044, 0, 1, 4, 1, 1, 32'h00000033, 0, 4'b1101};
    vecs[15] = '{0, 1, 0, 0, 0, 32'h0,        0, 1, 4, 1, 1, 32'h00000033, 1, 4'b1101};
    vecs[16] = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 4, 1, 1, 32'h00000033, 0, 4'b1101};
    vecs[17] = '{0, 1, 0, 0, 0, 32'h0,        1, 1, 4, 0, 0, 32'h0,        0, 4'b1111};
    b_fch  = '{0, 0, 1, 2, 3};
    b_frob = '{0, 1, 0, 0, 0};
    b_rch  = '{0, 1, 2, 3, 0};
    b_rrob = '{0, 0, 0, 0, 1};

    // Reset values, then ready rises one clock after release.
    set_idle();
    rst_i = 1'b0;
    #2;
    check("rst_sc_ready", sc_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_empty", rob_empty, 4'b1111);
    check("rst_err", rob_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    #1 check("sc_ready_before_clk", sc_ready, 1'b0);
    next();
    check("sc_ready_after_clk", sc_ready, 1'b1);

    // Table: out-of-order fills on ch1, unallocated and duplicate fills.
    for (int i = 0; i < 18; i++) begin
      alloc_valid = vecs[i].av;
      alloc_ch    = vecs[i].ach;
      sc_valid    = vecs[i].fv;
      sc_ch       = vecs[i].fch;
      sc_rob      = vecs[i].frob;
      sc_data     = 128'(vecs[i].fdata);
      rsp_ready   = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_alloc_ready", i), alloc_ready, vecs[i].e_ar);
      check($sformatf("v%0d_alloc_rob", i), alloc_rob, vecs[i].e_rob);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].e_v);
      if (vecs[i].e_v) begin
        check($sformatf("v%0d_rsp_ch", i), rsp_ch, vecs[i].e_ch);
        check($sformatf("v%0d_rsp_data", i), rsp_data, 128'(vecs[i].e_data));
      end
      check($sformatf("v%0d_err", i), rob_err, vecs[i].e_err);
      check($sformatf("v%0d_empty", i), rob_empty, vecs[i].e_empty);
      $display("vec %0d: valid=%0b ch=%0d data=%0h err=%0b empty=%b",
               i, rsp_valid, rsp_ch, rsp_data, rob_err, rob_empty);
      next();
    end
    set_idle();

    // Fill ch0 to full, wrap the tail, same-cycle alloc and release.
    for (int r = 0; r < 8; r++) alloc(2'd0, 3'(r), 1'b1);
    alloc(2'd0, 3'd0, 1'b0);
    fill(2'd0, 3'd0, 128'h100);
    #1 check("wrap_no_rsp", rsp_valid, 1'b0);
    next();
    sc_valid = 1'b0;
    alloc_ch = 2'd0;
    #1 expect_rsp("wrap_r0", 2'd0, 128'h100);
    check("wrap_full_ready", alloc_ready, 1'b0);
    next();
    fill(2'd0, 3'd1, 128'h101);
    alloc(2'd0, 3'd0, 1'b1);
    fill(2'd0, 3'd2, 128'h102);
    alloc_ch = 2'd0;
    #1 check("wrap_full_again", alloc_ready, 1'b0);
    expect_rsp("wrap_r1", 2'd0, 128'h101);
    next();
    sc_valid = 1'b0;
    #1 expect_rsp("wrap_r2", 2'd0, 128'h102);
    alloc(2'd0, 3'd1, 1'b1);
    alloc(2'd0, 3'd2, 1'b1);
    alloc(2'd0, 3'd0, 1'b0);

    // Reset with ch0 full, then round-robin over all four channels.
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    next();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) alloc(2'(b_fch[i]), 3'(b_frob[i]), 1'b1);
    for (int i = 0; i < 5; i++) begin
      fill(2'(b_fch[i]), 3'(b_frob[i]), 128'(4096 + 16 * b_fch[i] + b_frob[i]));
      next();
    end
    sc_valid  = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 expect_rsp($sformatf("rr%0d", i), 2'(b_rch[i]), 128'(4096 + 16 * b_rch[i] + b_rrob[i]));
      next();
    end
    check("rr_drained", rsp_valid, 1'b0);

    // One ch2 transaction so channel 0 would win a fresh arbitration.
    alloc(2'd2, 3'd1, 1'b1);
    fill(2'd2, 3'd1, 128'h2201);
    #1 check("mini_no_rsp", rsp_valid, 1'b0);
    next();
    sc_valid = 1'b0;
    #1 expect_rsp("mini", 2'd2, 128'h2201);
    next();

    // Stall ch2 for five cycles while ch0 becomes ready.
    alloc(2'd2, 3'd2, 1'b1);
    alloc(2'd0, 3'd2, 1'b1);
    rsp_ready = 1'b0;
    fill(2'd2, 3'd2, 128'hC2);
    #1 check("hold_no_rsp", rsp_valid, 1'b0);
    next();
    for (int k = 0; k < 5; k++) begin
      fill(2'd0, 3'd2, 128'hC0);
      sc_valid = (k == 0);
      #1 expect_rsp($sformatf("hold%0d", k), 2'd2, 128'hC2);
      next();
    end
    sc_valid  = 1'b0;
    rsp_ready = 1'b1;
    #1 expect_rsp("hold_accept", 2'd2, 128'hC2);
    next();
    expect_rsp("after_hold", 2'd0, 128'hC0);
    next();
    check("hold_drained", rsp_valid, 1'b0);

    // Mid-stream reset with five ch3 entries pending.
    for (int r = 1; r < 6; r++) alloc(2'd3, 3'(r), 1'b1);
    fill(2'd3, 3'd1, 128'h3301);
    next();
    set_idle();
    rsp_ready = 1'b0;
    #1 expect_rsp("pre_reset", 2'd3, 128'h3301);
    rst_i = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_empty", rob_empty, 4'b1111);
    check("midrst_sc_ready", sc_ready, 1'b0);
    @(posedge clk);
    #1 rst_i = 1'b1;
    next();
    alloc(2'd3, 3'd0, 1'b1);
    check("post_rst_empty", rob_empty, 4'b0111);
    check("post_rst_valid", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
